// File: rtl/configs_loader.sv
// configs_loader: replays a valid/ready stream of config words as one-hot latch writes with setup/hold cycles.
// Optional macro CFG_LOADER_CHECKSUM_EN adds a trailing XOR checksum word and io_error reporting.
`default_nettype none

module configs_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 27,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_start,
    input  logic                  io_in_valid,
    output logic                  io_in_ready,
    input  logic [DATA_WIDTH-1:0] io_in_data,
    output logic [DATA_WIDTH-1:0] io_d_out,
    output logic [NUM_WORDS-1:0]  io_configs_en,
    output logic                  io_busy,
    output logic                  io_done,
    output logic                  io_error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
`ifdef CFG_LOADER_CHECKSUM_EN
        CHECK  = 3'd6,
`endif
        DONE   = 3'd5
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);
    localparam logic [NUM_WORDS-1:0] EN_ONE   = NUM_WORDS'(1);

    state_t                  state;
    state_t                  state_next;
    logic [IDX_WIDTH-1:0]    idx;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [NUM_WORDS-1:0]    en_reg;
    logic                    start_fire;
    logic                    accept_fire;
    logic                    last_word;

    assign start_fire  = io_start && ((state == IDLE) || (state == DONE));
    assign accept_fire = (state == ACCEPT) && io_in_valid;
    assign last_word   = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        io_in_ready = 1'b0;
        io_busy     = 1'b1;
        io_done     = 1'b0;
        case (state)
            IDLE: begin
                io_busy = 1'b0;
                if (io_start) state_next = ACCEPT;
            end
            ACCEPT: begin
                io_in_ready = 1'b1;
                if (io_in_valid) state_next = SETUP;
            end
            SETUP:  state_next = STROBE;
            STROBE: state_next = HOLD;
            HOLD: begin
                if (last_word) begin
`ifdef CFG_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = ACCEPT;
                end
            end
`ifdef CFG_LOADER_CHECKSUM_EN
            CHECK: begin
                io_in_ready = 1'b1;
                if (io_in_valid) state_next = DONE;
            end
`endif
            DONE: begin
                io_busy = 1'b0;
                io_done = 1'b1;
                if (io_start) state_next = ACCEPT;
            end
            default: state_next = IDLE;
        endcase
    end

    // The strobe is registered from SETUP so io_configs_en is glitch-free and
    // only ever high for the single STROBE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            data_reg <= '0;
            en_reg   <= '0;
        end else begin
            en_reg <= (state == SETUP) ? (EN_ONE << idx) : '0;
            if (start_fire) begin
                idx <= '0;
            end else if ((state == HOLD) && !last_word) begin
                idx <= idx + 1'b1;
            end
            if (accept_fire) begin
                data_reg <= io_in_data;
            end
        end
    end

    assign io_d_out      = data_reg;
    assign io_configs_en = en_reg;

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] xor_reg;
    logic                  error_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xor_reg   <= '0;
            error_reg <= 1'b0;
        end else if (start_fire) begin
            xor_reg   <= '0;
            error_reg <= 1'b0;
        end else if (accept_fire) begin
            xor_reg <= xor_reg ^ io_in_data;
        end else if ((state == CHECK) && io_in_valid) begin
            error_reg <= (io_in_data != xor_reg);
        end
    end

    assign io_error = error_reg;
`else
    assign io_error = 1'b0;
`endif

endmodule

`default_nettype wire
